aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. It accepts a key/plaintext pair over a valid/ready handshake and holds the 128-bit cipher state. It sequences one external single-round datapath through rounds 1..10, slicing the round key from the key-expansion output, and returns the ciphertext over a second valid/ready handshake. It sits between the host interface and the `expand_key` / round-function logic, replacing the unrolled encrypt path when area matters.

---
 rtl/aes_round_sequencer.sv | 149 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encrypt controller: sequences an external single-round datapath
// through rounds 1..10, slicing round keys from the expander and caching the last key.
module aes_round_sequencer #(
  parameter int unsigned KEY_LAT = 32'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_key,
  input  logic [127:0]  in_plain,
  output logic [127:0]  key_out,
  input  logic [1407:0] expanded_key,
  output logic [127:0]  rnd_state,
  output logic [127:0]  rnd_key,
  output logic          rnd_last,
  input  logic [127:0]  rnd_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_cypher,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYWAIT = 2'd1,
    ROUND   = 2'd2,
    DONE    = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] WAIT_INIT  = (KEY_LAT > 32'd0) ? 4'(KEY_LAT - 32'd1) : 4'd0;

  fsm_t         fsm_r, fsm_nxt_s;
  logic [127:0] state_r, state_nxt_s;
  logic [127:0] key_r, key_nxt_s;
  logic [127:0] cypher_r, cypher_nxt_s;
  logic [3:0]   round_r, round_nxt_s;
  logic [3:0]   wait_r, wait_nxt_s;
  logic         key_vld_r, key_vld_nxt_s;
  logic         out_valid_r, busy_r, rnd_last_r;
  logic [10:0]  key_idx_s;
  logic [127:0] rnd_key_s;

  // Next-state and datapath update logic
  always_comb begin
    fsm_nxt_s     = fsm_r;
    state_nxt_s   = state_r;
    key_nxt_s     = key_r;
    cypher_nxt_s  = cypher_r;
    round_nxt_s   = round_r;
    wait_nxt_s    = wait_r;
    key_vld_nxt_s = key_vld_r;
    case (fsm_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = in_plain ^ in_key;
          key_nxt_s   = in_key;
          round_nxt_s = 4'd1;
          // A repeated key already settled in the expander, so no wait is needed
          if ((!key_vld_r || (in_key != key_r)) && (KEY_LAT > 32'd0)) begin
            fsm_nxt_s     = KEYWAIT;
            wait_nxt_s    = WAIT_INIT;
            key_vld_nxt_s = 1'b1;
          end else begin
            fsm_nxt_s = ROUND;
          end
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      KEYWAIT: begin
        if (wait_r == 4'd0) begin
          fsm_nxt_s = ROUND;
        end else begin
          wait_nxt_s = wait_r - 4'd1;
        end
      end
      ROUND: begin
        state_nxt_s = rnd_result;
        if (round_r == LAST_ROUND) begin
          fsm_nxt_s    = DONE;
          cypher_nxt_s = rnd_result;
        end else begin
          round_nxt_s = round_r + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_nxt_s   = IDLE;
          round_nxt_s = 4'd0;
        end else begin
          fsm_nxt_s = DONE;
        end
      end
      default: begin
        fsm_nxt_s   = IDLE;
        round_nxt_s = 4'd0;
      end
    endcase
  end

  // Round-key slice selection, clamped to round 0 for out-of-range counts
  always_comb begin
    if (round_r > LAST_ROUND) begin
      key_idx_s = 11'd0;
    end else begin
      key_idx_s = 11'(round_r) * 11'd128;
    end
    rnd_key_s = expanded_key[11'd1407 - key_idx_s -: 128];
  end

  // State, key cache and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      state_r     <= 128'd0;
      key_r       <= 128'd0;
      cypher_r    <= 128'd0;
      round_r     <= 4'd0;
      wait_r      <= 4'd0;
      key_vld_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      rnd_last_r  <= 1'b0;
    end else begin
      fsm_r       <= fsm_nxt_s;
      state_r     <= state_nxt_s;
      key_r       <= key_nxt_s;
      cypher_r    <= cypher_nxt_s;
      round_r     <= round_nxt_s;
      wait_r      <= wait_nxt_s;
      key_vld_r   <= key_vld_nxt_s;
      out_valid_r <= (fsm_nxt_s == DONE);
      busy_r      <= (fsm_nxt_s != IDLE);
      rnd_last_r  <= (fsm_nxt_s == ROUND) && (round_nxt_s == LAST_ROUND);
    end
  end

  assign in_ready   = rst_n && (fsm_r == IDLE);
  assign key_out    = key_r;
  assign rnd_state  = state_r;
  assign rnd_key    = rnd_key_s;
  assign rnd_last   = rnd_last_r;
  assign out_valid  = out_valid_r;
  assign out_cypher = cypher_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three instances (KEY_LAT 1, 0, 15) with a behavioural
// AES round unit and delayed key expander, checked against an AES-128 reference model.
module tb_aes_round_sequencer;

  logic clk;
  logic rst_n;
  logic stub_mode;
  int   tests;
  int   fails;

  logic         in_valid_a  [3];
  logic [127:0] in_key_a    [3];
  logic [127:0] in_plain_a  [3];
  logic         out_ready_a [3];
  wire          in_ready_w  [3];
  wire  [127:0] key_out_w   [3];
  wire  [127:0] rnd_state_w [3];
  wire  [127:0] rnd_key_w   [3];
  wire          rnd_last_w  [3];
  wire          out_valid_w [3];
  wire  [127:0] out_cypher_w[3];
  wire          busy_w      [3];

  logic         kv       [3];
  logic [127:0] last_key [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] e;
    logic [7:0] s;
    inv = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, a);
    end
    s = inv ^ 8'h63;
    for (int k = 1; k <= 4; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
    return s;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127 - 8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[c*4 + w] = b[((c + w) % 4)*4 + w];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] e;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) e[1407 - 32*i -: 32] = w[i];
    return e;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] plain);
    logic [1407:0] e;
    logic [127:0] s;
    e = expand(key);
    s = plain ^ key;
    for (int r = 1; r <= 10; r++) s = aes_round(s, e[1407 - 128*r -: 128], r == 10);
    return s;
  endfunction

  function automatic logic [127:0] tag_of(input int r);
    logic [7:0] t;
    t = 8'(r);
    return {4{8'ha0 ^ t, 8'h5c, t, 8'he7}};
  endfunction

  function automatic logic [1407:0] tagged_all();
    logic [1407:0] e;
    for (int r = 0; r <= 10; r++) e[1407 - 128*r -: 128] = tag_of(r);
    return e;
  endfunction

  function automatic logic [127:0] stub_round(input logic [127:0] s, input logic [127:0] k);
    return {s[126:0], s[127]} ^ k ^ 128'h1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : env
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    logic [127:0]  kpipe [16];
    logic [127:0]  kd;
    logic [1407:0] exp_key;
    logic [127:0]  res;

    always @(posedge clk) begin
      kpipe[0] <= key_out_w[g];
      for (int i = 1; i < 16; i++) kpipe[i] <= kpipe[i-1];
    end

    if (L == 0) begin : comb_k
      assign kd = key_out_w[g];
    end else begin : dly_k
      assign kd = kpipe[L-1];
    end

    assign exp_key = (g == 0 && stub_mode) ? tagged_all() : expand(kd);
    assign res = (g == 0 && stub_mode) ? stub_round(rnd_state_w[g], rnd_key_w[g])
                                       : aes_round(rnd_state_w[g], rnd_key_w[g], rnd_last_w[g]);

    aes_round_sequencer #(.KEY_LAT(L)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid_a[g]),
      .in_ready     (in_ready_w[g]),
      .in_key       (in_key_a[g]),
      .in_plain     (in_plain_a[g]),
      .key_out      (key_out_w[g]),
      .expanded_key (exp_key),
      .rnd_state    (rnd_state_w[g]),
      .rnd_key      (rnd_key_w[g]),
      .rnd_last     (rnd_last_w[g]),
      .rnd_result   (res),
      .out_valid    (out_valid_w[g]),
      .out_ready    (out_ready_a[g]),
      .out_cypher   (out_cypher_w[g]),
      .busy         (busy_w[g])
    );
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request on instance idx, with `hold` backpressure cycles in DONE
  task automatic run_block(input int idx, input logic [127:0] key, input logic [127:0] plain,
                           input logic [127:0] exp_c, input int hold);
    int n;
    int lastcnt;
    int exp_n;
    int lat;
    lat = lat_of(idx);
    exp_n = (lat > 0 && (!kv[idx] || key != last_key[idx])) ? 10 + lat : 10;
    kv[idx] = 1'b1;
    last_key[idx] = key;
    n = 0;
    while (!in_ready_w[idx] && n < 50) begin
      tick();
      n++;
    end
    chk($sformatf("in_ready_idle[%0d]", idx), in_ready_w[idx], 1);
    in_key_a[idx] = key;
    in_plain_a[idx] = plain;
    in_valid_a[idx] = 1'b1;
    tick();
    in_valid_a[idx] = 1'b0;
    in_key_a[idx] = rand128();
    in_plain_a[idx] = rand128();
    chk($sformatf("busy_after_accept[%0d]", idx), busy_w[idx], 1);
    n = 0;
    lastcnt = 0;
    while (!out_valid_w[idx] && n < 60) begin
      if (rnd_last_w[idx]) lastcnt++;
      tick();
      n++;
    end
    chk($sformatf("latency[%0d]", idx), n, exp_n);
    chk($sformatf("rnd_last_cycles[%0d]", idx), lastcnt, 1);
    chk($sformatf("cipher[%0d]", idx), out_cypher_w[idx], exp_c);
    for (int i = 0; i < hold; i++) begin
      in_valid_a[idx] = i[0];
      in_key_a[idx] = rand128();
      in_plain_a[idx] = rand128();
      tick();
      chk($sformatf("bp_valid[%0d]", idx), out_valid_w[idx], 1);
      chk($sformatf("bp_cipher[%0d]", idx), out_cypher_w[idx], exp_c);
      chk($sformatf("bp_in_ready[%0d]", idx), in_ready_w[idx], 0);
    end
    in_valid_a[idx] = 1'b0;
    out_ready_a[idx] = 1'b1;
    tick();
    out_ready_a[idx] = 1'b0;
    chk($sformatf("valid_drop[%0d]", idx), out_valid_w[idx], 0);
    chk($sformatf("busy_drop[%0d]", idx), busy_w[idx], 0);
    chk($sformatf("in_ready_back[%0d]", idx), in_ready_w[idx], 1);
  endtask

  initial begin
    logic [127:0] k_fips, p_fips, k2, p2, k0, p0, es, kr, pr, exp5;
    logic [1407:0] ek;
    int idx;
    tests = 0;
    fails = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    stub_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0;
      in_key_a[i] = 128'd0;
      in_plain_a[i] = 128'd0;
      out_ready_a[i] = 1'b0;
      kv[i] = 1'b0;
      last_key[i] = 128'd0;
    end
    k_fips = 128'h000102030405060708090a0b0c0d0e0f;
    p_fips = 128'h00112233445566778899aabbccddeeff;
    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p2 = 128'h3243f6a8885a308d313198a2e0370734;

    repeat (2) tick();
    chk("rst_in_ready", in_ready_w[0], 0);
    chk("rst_out_valid", out_valid_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_rnd_last", rnd_last_w[0], 0);
    chk("rst_out_cypher", out_cypher_w[0], 128'd0);
    chk("rst_key_out", key_out_w[0], 128'd0);
    chk("rst_rnd_state", rnd_state_w[0], 128'd0);
    chk("rst_rnd_key", rnd_key_w[0], tag_of(0));
    chk("rst_busy_lat0", busy_w[1], 0);
    chk("rst_busy_lat15", busy_w[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", in_ready_w[0], 1);

    // Round-key selection with tagged slices and a stub round unit
    k0 = rand128();
    p0 = rand128();
    in_key_a[0] = k0;
    in_plain_a[0] = p0;
    in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    kv[0] = 1'b1;
    last_key[0] = k0;
    chk("stub_keywait_busy", busy_w[0], 1);
    chk("stub_key_out", key_out_w[0], k0);
    tick();
    es = p0 ^ k0;
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("stub_rnd_key_r%0d", r), rnd_key_w[0], tag_of(r));
      chk($sformatf("stub_rnd_state_r%0d", r), rnd_state_w[0], es);
      chk($sformatf("stub_rnd_last_r%0d", r), rnd_last_w[0], (r == 10) ? 1 : 0);
      es = stub_round(es, tag_of(r));
      tick();
    end
    chk("stub_out_valid", out_valid_w[0], 1);
    chk("stub_cipher", out_cypher_w[0], es);
    out_ready_a[0] = 1'b1;
    tick();
    out_ready_a[0] = 1'b0;
    chk("stub_idle_round0_key", rnd_key_w[0], tag_of(0));
    stub_mode = 1'b0;

    // Known-answer vectors, cached key and key change, backpressure
    run_block(0, k_fips, p_fips, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    run_block(0, k_fips, 128'hffeeddccbbaa99887766554433221100,
              aes_enc(k_fips, 128'hffeeddccbbaa99887766554433221100), 20);
    run_block(0, k2, p2, 128'h3925841d02dc09fbdc118597196a0b32, 0);

    // Reset during round 5 of a cached-key block
    in_key_a[0] = k2;
    in_plain_a[0] = p0;
    in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    repeat (4) tick();
    ek = expand(k2);
    exp5 = ek[1407 - 128*5 -: 128];
    chk("mid_round5_key", rnd_key_w[0], exp5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_w[0], 0);
    chk("mid_rst_out_valid", out_valid_w[0], 0);
    chk("mid_rst_in_ready", in_ready_w[0], 0);
    chk("mid_rst_rnd_state", rnd_state_w[0], 128'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) kv[i] = 1'b0;
    run_block(0, k2, p2, 128'h3925841d02dc09fbdc118597196a0b32, 0);

    // Parameter sweep: combinational expander and maximum latency
    run_block(1, k_fips, p_fips, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    run_block(2, k2, p2, 128'h3925841d02dc09fbdc118597196a0b32, 0);

    // Randomized traffic across all instances, mixing repeated and fresh keys
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(0, 2);
      kr = ($urandom_range(0, 1) == 1) ? last_key[idx] : rand128();
      pr = rand128();
      run_block(idx, kr, pr, aes_enc(kr, pr), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
